// File: rtl/fincfdec_pulse_shaper_if.sv
// fincfdec_pulse_shaper_if: request inputs and pin/status outputs of one FINC/FDEC pulse shaper
interface fincfdec_pulse_shaper_if #(parameter int PEND_W = 8, parameter int CNT_W = 16);
    logic              inc_req;
    logic              dec_req;
    logic              clear_overflow;
    logic              finc_pin;
    logic              fdec_pin;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              overflow_sticky;
    logic [CNT_W-1:0]  inc_count;
    logic [CNT_W-1:0]  dec_count;
    modport master (
        output inc_req, dec_req, clear_overflow,
        input  finc_pin, fdec_pin, busy, pending, overflow_sticky, inc_count, dec_count
    );
    modport slave (
        input  inc_req, dec_req, clear_overflow,
        output finc_pin, fdec_pin, busy, pending, overflow_sticky, inc_count, dec_count
    );
endinterface

// File: rtl/fincfdec_pulse_shaper.sv
// fincfdec_pulse_shaper: accumulates FINC/FDEC requests as a signed backlog and replays them
// as pin pulses honouring the clock generator's minimum high time and inter-update gap.
module fincfdec_pulse_shaper #(
    parameter int PULSE_CYCLES   = 8,
    parameter int HOLDOFF_CYCLES = 64,
    parameter int PEND_W         = 8,
    parameter int CNT_W          = 16
) (
    input logic clk,
    input logic rst_n,
    fincfdec_pulse_shaper_if.slave bus
);
    localparam int TMAX = (PULSE_CYCLES > HOLDOFF_CYCLES) ? PULSE_CYCLES : HOLDOFF_CYCLES;
    localparam int TW = $clog2(TMAX) + 1;
    localparam logic signed [PEND_W:0] ONE = 1;
    localparam logic signed [PEND_W:0] LIM = (PEND_W+1)'((1 << (PEND_W-1)) - 1);

    typedef enum logic [1:0] {IDLE, PULSE, HOLDOFF} state_t;

    state_t state, stateNext;
    logic [TW-1:0] timer, timerNext;
    logic dirInc, dirIncNext, launch, drop;
    logic fincPin, fdecPin, overflow;
    logic [PEND_W-1:0] pending, pendingNext;
    logic signed [PEND_W:0] launchTerm, deltaTerm, afterLaunch, sum;
    logic [CNT_W-1:0] incCount, decCount;

    always_comb begin
        stateNext  = state;
        timerNext  = timer;
        dirIncNext = dirInc;
        launch     = 1'b0;
        case (state)
            IDLE: if (pending != '0) begin
                launch     = 1'b1;
                dirIncNext = !pending[PEND_W-1];
                stateNext  = PULSE;
                timerNext  = TW'(PULSE_CYCLES - 1);
            end
            PULSE: if (timer == '0) begin
                stateNext = HOLDOFF;
                timerNext = TW'(HOLDOFF_CYCLES - 1);
            end else timerNext = timer - 1'b1;
            HOLDOFF: if (timer == '0) stateNext = IDLE;
                     else timerNext = timer - 1'b1;
            default: stateNext = IDLE;
        endcase
    end

    // The launch is subtracted before the request is added, so a launch can make room for it.
    assign launchTerm  = !launch ? '0 : dirIncNext ? ONE : -ONE;
    assign deltaTerm   = (bus.inc_req == bus.dec_req) ? '0 : bus.inc_req ? ONE : -ONE;
    assign afterLaunch = $signed({pending[PEND_W-1], pending}) - launchTerm;
    assign sum         = afterLaunch + deltaTerm;
    assign drop        = (sum > LIM) || (sum < -LIM);
    assign pendingNext = drop ? afterLaunch[PEND_W-1:0] : sum[PEND_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            timer    <= '0;
            dirInc   <= 1'b0;
            pending  <= '0;
            overflow <= 1'b0;
            fincPin  <= 1'b0;
            fdecPin  <= 1'b0;
            incCount <= '0;
            decCount <= '0;
        end else begin
            state    <= stateNext;
            timer    <= timerNext;
            dirInc   <= dirIncNext;
            pending  <= pendingNext;
            overflow <= drop | (overflow & ~bus.clear_overflow);
            fincPin  <= (stateNext == PULSE) && dirIncNext;
            fdecPin  <= (stateNext == PULSE) && !dirIncNext;
            if (launch && dirIncNext) incCount <= incCount + 1'b1;
            if (launch && !dirIncNext) decCount <= decCount + 1'b1;
        end
    end

    assign bus.finc_pin        = fincPin;
    assign bus.fdec_pin        = fdecPin;
    assign bus.busy            = state != IDLE;
    assign bus.pending         = pending;
    assign bus.overflow_sticky = overflow;
    assign bus.inc_count       = incCount;
    assign bus.dec_count       = decCount;
endmodule

// File: tb/tb_fincfdec_pulse_shaper.sv
// tb_fincfdec_pulse_shaper: scoreboard bench; expected pulses are queued as requests are driven
// and matched when each pin pulse ends.
module tb_fincfdec_pulse_shaper;
    localparam int PW = 4;

    typedef struct {
        bit isInc;
        int rise;
        int width;
    } pulse_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    pulse_t sb[$];
    bit bothHigh = 1'b0;
    bit prevHigh = 1'b0;
    bit riseInc;
    int riseCyc, width;
    pulse_t e;

    fincfdec_pulse_shaper_if #(.PEND_W(PW), .CNT_W(16)) bus ();

    fincfdec_pulse_shaper #(
        .PULSE_CYCLES(4), .HOLDOFF_CYCLES(8), .PEND_W(PW), .CNT_W(16)
    ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int pend();
        return int'($signed(bus.pending));
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expectPulse(input bit isInc, input int rise, input int w = 4);
        pulse_t p;
        p.isInc = isInc;
        p.rise  = rise;
        p.width = w;
        sb.push_back(p);
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((bus.busy || sb.size() != 0) && n < 600) begin
            tick();
            n++;
        end
        check("drain_queue", sb.size(), 0);
        check("drain_busy", int'(bus.busy), 0);
    endtask

    // Pin monitor: measure each pulse and match it against the oldest expected one.
    always @(negedge clk) begin
        if (bus.finc_pin && bus.fdec_pin) bothHigh = 1'b1;
        if ((bus.finc_pin || bus.fdec_pin) && !prevHigh) begin
            riseCyc = cyc;
            riseInc = bus.finc_pin;
            width   = 0;
        end
        if (bus.finc_pin || bus.fdec_pin) width++;
        if (!(bus.finc_pin || bus.fdec_pin) && prevHigh) begin
            check("sb_nonempty", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("pulse_dir", int'(riseInc), int'(e.isInc));
                check("pulse_rise", riseCyc, e.rise);
                check("pulse_width", width, e.width);
            end
        end
        prevHigh = bus.finc_pin || bus.fdec_pin;
    end

    initial begin
        int k;
        bit sawBusy;
        bus.inc_req = 1'b0;
        bus.dec_req = 1'b0;
        bus.clear_overflow = 1'b0;
        tick(3);
        check("rst_finc", int'(bus.finc_pin), 0);
        check("rst_fdec", int'(bus.fdec_pin), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_pending", pend(), 0);
        check("rst_ovf", int'(bus.overflow_sticky), 0);
        check("rst_inc_cnt", int'(bus.inc_count), 0);
        check("rst_dec_cnt", int'(bus.dec_count), 0);
        rst_n = 1'b1;
        tick(6);

        // Single FINC request
        k = cyc;
        expectPulse(1'b1, k + 2);
        bus.inc_req = 1'b1;
        tick();
        bus.inc_req = 1'b0;
        check("s1_pending_n1", pend(), 1);
        tick();
        check("s1_pending_n2", pend(), 0);
        check("s1_finc_n2", int'(bus.finc_pin), 1);
        tick(11);
        check("s1_busy_n13", int'(bus.busy), 1);
        tick();
        check("s1_busy_n14", int'(bus.busy), 0);
        check("s1_inc_cnt", int'(bus.inc_count), 1);
        waitDrain();

        // Three back-to-back FDEC requests
        k = cyc;
        for (int i = 0; i < 3; i++) expectPulse(1'b0, k + 2 + 13 * i);
        bus.dec_req = 1'b1;
        tick(3);
        bus.dec_req = 1'b0;
        waitDrain();
        check("s2_dec_cnt", int'(bus.dec_count), 3);
        check("s2_pending", pend(), 0);

        // Simultaneous requests cancel
        sawBusy = 1'b0;
        bus.inc_req = 1'b1;
        bus.dec_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            sawBusy |= bus.busy;
        end
        bus.inc_req = 1'b0;
        bus.dec_req = 1'b0;
        tick(3);
        check("s3_pending", pend(), 0);
        check("s3_busy_seen", int'(sawBusy), 0);
        check("s3_inc_cnt", int'(bus.inc_count), 1);

        // Saturation at +7 with clear/drop collision, then a clean clear
        k = cyc;
        for (int i = 0; i < 9; i++) expectPulse(1'b1, k + 2 + 13 * i);
        for (int i = 0; i < 20; i++) begin
            bus.inc_req = 1'b1;
            bus.clear_overflow = (i == 18);
            if (i == 8) check("s4_ovf_before_drop", int'(bus.overflow_sticky), 0);
            if (i == 9) check("s4_ovf_after_drop", int'(bus.overflow_sticky), 1);
            if (i == 19) check("s4_ovf_clear_vs_drop", int'(bus.overflow_sticky), 1);
            tick();
        end
        bus.inc_req = 1'b0;
        bus.clear_overflow = 1'b1;
        check("s4_pending_sat", pend(), 7);
        check("s4_ovf_held", int'(bus.overflow_sticky), 1);
        tick();
        bus.clear_overflow = 1'b0;
        check("s4_ovf_cleared", int'(bus.overflow_sticky), 0);
        waitDrain();
        check("s4_inc_cnt", int'(bus.inc_count), 10);
        check("s4_pending_end", pend(), 0);

        // Opposing requests during a FINC pulse flip the backlog sign
        k = cyc;
        expectPulse(1'b1, k + 2);
        for (int i = 0; i < 3; i++) expectPulse(1'b0, k + 15 + 13 * i);
        bus.inc_req = 1'b1;
        tick();
        bus.inc_req = 1'b0;
        tick();
        bus.dec_req = 1'b1;
        tick(3);
        bus.dec_req = 1'b0;
        check("s5_pending_neg", pend(), -3);
        check("s5_finc_still_high", int'(bus.finc_pin), 1);
        waitDrain();
        check("s5_inc_cnt", int'(bus.inc_count), 11);
        check("s5_dec_cnt", int'(bus.dec_count), 6);

        // Reset in the second cycle of a FINC pulse
        k = cyc;
        expectPulse(1'b1, k + 2, 1);
        bus.inc_req = 1'b1;
        tick();
        bus.inc_req = 1'b0;
        tick(2);
        check("s6_finc_before_rst", int'(bus.finc_pin), 1);
        rst_n = 1'b0;
        #1;
        check("s6_finc_async_low", int'(bus.finc_pin), 0);
        tick(2);
        rst_n = 1'b1;
        tick();
        check("s6_pending", pend(), 0);
        check("s6_busy", int'(bus.busy), 0);
        check("s6_ovf", int'(bus.overflow_sticky), 0);
        check("s6_inc_cnt", int'(bus.inc_count), 0);
        check("s6_dec_cnt", int'(bus.dec_count), 0);
        check("s6_fdec", int'(bus.fdec_pin), 0);
        sawBusy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            sawBusy |= bus.busy;
        end
        check("s6_no_restart", int'(sawBusy), 0);
        check("s6_queue", sb.size(), 0);
        check("pins_exclusive", int'(bothHigh), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fincfdec_pulse_shaper.md
Name: fincfdec_pulse_shaper

Overview:
- Sits directly downstream of the clock-control logic in each clock domain. Consumes its single-cycle speed-up/slow-down requests (FINC/FDEC) and drives the FINC/FDEC pins of the external programmable clock generator.
- Accumulates requests as a signed net backlog, then replays them as pulses that meet the generator's minimum high time and minimum inter-update gap.
- One instance per domain (A, B), placed between the controller and the top-level FINC/FDEC pads.

Parameters:
- PULSE_CYCLES, 8, cycles each pin pulse is held high; legal range >=1
- HOLDOFF_CYCLES, 64, cycles both pins are held low after a pulse before the next may start; legal range >=1
- PEND_W, 8, width of the signed backlog counter; legal range >=2
- CNT_W, 16, width of the issued-pulse counters

Ports:
- clk, input, 1, domain clock (clkA or clkB)
- rst_n, input, 1, asynchronous active-low reset
- inc_req, input, 1, one FINC request per cycle when high
- dec_req, input, 1, one FDEC request per cycle when high
- clear_overflow, input, 1, clears overflow_sticky
- finc_pin, output, 1, registered FINC pin drive
- fdec_pin, output, 1, registered FDEC pin drive
- busy, output, 1, high when state is not IDLE
- pending, output, PEND_W, signed net backlog (positive = FINCs owed)
- overflow_sticky, output, 1, set when a request is dropped at saturation
- inc_count, output, CNT_W, FINC pulses launched, wrapping
- dec_count, output, CNT_W, FDEC pulses launched, wrapping

Behaviour:
- Reset (async assert, sync release): state IDLE; finc_pin, fdec_pin, busy, overflow_sticky = 0; pending, inc_count, dec_count = 0; timer = 0.
- Request delta per cycle: inc_req and dec_req both high gives 0 (they cancel). inc only gives +1. dec only gives -1.
- Launch term L: +1 when a FINC pulse launches this cycle, -1 for an FDEC launch, else 0.
- Backlog update each cycle: pending_next = pending + delta - L.
- Saturation: pending is limited to ±(2^(PEND_W-1)-1). When pending_next would exceed this range, the request is dropped: pending holds its limit and overflow_sticky is set next cycle. A launch in the same cycle is applied first, so no request is dropped if the launch frees room.
- overflow_sticky: cleared by clear_overflow. If a new drop occurs in the same cycle as clear_overflow, set wins.
- FSM states: IDLE, PULSE, HOLDOFF.
  - IDLE: if registered pending > 0, launch FINC; if < 0, launch FDEC. Go to PULSE with timer = PULSE_CYCLES-1 and the direction latched. The matching count increments the same cycle.
  - PULSE: the latched pin is high and the other pin is low. Decrement timer. At timer == 0, go to HOLDOFF with timer = HOLDOFF_CYCLES-1.
  - HOLDOFF: both pins low. At timer == 0, go to IDLE.
- Pins are registered from next-state. Both pins are never high in the same cycle.
- Latency:
  - Request at cycle N updates pending at N+1.
  - From IDLE, the launch decision is at N+1 and the pin rises at N+2.
  - The pin stays high for exactly PULSE_CYCLES cycles.
  - The minimum period between consecutive pulse rising edges is PULSE_CYCLES + HOLDOFF_CYCLES + 1 cycles, since IDLE costs one cycle.
- Direction is fixed at launch. Opposing requests during PULSE/HOLDOFF only adjust pending, which may cross zero; the next launch uses the new sign.
- pending == 0 in IDLE: no launch; remain IDLE.
- Counters wrap modulo 2^CNT_W with no flag.
- Reset asserted mid-pulse: pins drop low asynchronously and all state is lost. No partial pulse resumes.

Test Plan:
- PULSE_CYCLES=4, HOLDOFF_CYCLES=8. Single inc_req pulse at cycle 10 -> pending=1 at cycle 11; finc_pin high cycles 12-15; pending=0 at 12; fdec_pin never high; inc_count=1; busy low again at cycle 24.
- Three consecutive dec_req (cycles 10-12) -> three fdec_pin pulses of 4 cycles, rising edges 13 cycles apart (cycles 12, 25, 38); dec_count=3; pending returns to 0.
- inc_req and dec_req both high for 20 cycles -> pending stays 0; no pin activity; busy stays 0.
- PEND_W=4, inc_req held high 20 cycles while the first pulse runs -> pending saturates at 7; overflow_sticky=1. Asserting clear_overflow on the same cycle as a further drop leaves overflow_sticky=1; clearing with no drop -> 0.
- Start a FINC pulse with pending=1, then apply 3 dec_req during PULSE -> the FINC pulse completes its full 4 cycles; pending=-3; next three pulses are FDEC.
- rst_n low in the 2nd cycle of a FINC pulse -> finc_pin=0 immediately; after release all outputs are 0 and no pulse occurs without a new request.
